// File: rtl/accelerator_dnc_pkg.sv
// Shared FSM state encoding and fixed-point constants for the DNC memory-update accelerator.
// Data constants assume the default 64-bit word with 16 fraction bits; modules cast them to their own widths.
package accelerator_dnc_pkg;

    typedef enum logic [2:0] {
        STARTER  = 3'd0,
        LOAD_EV  = 3'd1,
        LOAD_W   = 3'd2,
        STREAM_M = 3'd3,
        ENDER    = 3'd4
    } state_t;

    localparam int DNC_DATA_SIZE    = 64;
    localparam int DNC_CONTROL_SIZE = 64;
    localparam int DNC_FRAC_BITS    = 16;

    localparam logic [DNC_DATA_SIZE-1:0]    ZERO_DATA    = '0;
    localparam logic [DNC_DATA_SIZE-1:0]    ONE_DATA     = DNC_DATA_SIZE'(1) << DNC_FRAC_BITS;
    localparam logic [DNC_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
    localparam logic [DNC_CONTROL_SIZE-1:0] ONE_CONTROL  = DNC_CONTROL_SIZE'(1);

endpackage

// File: rtl/accelerator_memory_update_if.sv
// Streaming bus of the memory-update accelerator: control, e/v/w/M input strobes and output strobes.
// The master drives START, sizes and element inputs; the slave (the accelerator) drives the rest.
interface accelerator_memory_update_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 ERROR;
    logic [DATA_SIZE-1:0] SIZE_N_IN;
    logic [DATA_SIZE-1:0] SIZE_W_IN;
    logic [DATA_SIZE-1:0] E_IN;
    logic                 E_IN_K_ENABLE;
    logic [DATA_SIZE-1:0] V_IN;
    logic                 V_IN_K_ENABLE;
    logic [DATA_SIZE-1:0] W_IN;
    logic                 W_IN_J_ENABLE;
    logic [DATA_SIZE-1:0] M_IN;
    logic                 M_IN_J_ENABLE;
    logic                 M_IN_K_ENABLE;
    logic [DATA_SIZE-1:0] M_OUT;
    logic                 M_OUT_J_ENABLE;
    logic                 M_OUT_K_ENABLE;
    logic                 W_OUT_J_ENABLE;
    logic                 V_OUT_K_ENABLE;
    logic                 E_OUT_K_ENABLE;

    modport master (
        output START, SIZE_N_IN, SIZE_W_IN,
        output E_IN, E_IN_K_ENABLE, V_IN, V_IN_K_ENABLE,
        output W_IN, W_IN_J_ENABLE, M_IN, M_IN_J_ENABLE, M_IN_K_ENABLE,
        input  READY, ERROR, M_OUT, M_OUT_J_ENABLE, M_OUT_K_ENABLE,
        input  W_OUT_J_ENABLE, V_OUT_K_ENABLE, E_OUT_K_ENABLE
    );

    modport slave (
        input  START, SIZE_N_IN, SIZE_W_IN,
        input  E_IN, E_IN_K_ENABLE, V_IN, V_IN_K_ENABLE,
        input  W_IN, W_IN_J_ENABLE, M_IN, M_IN_J_ENABLE, M_IN_K_ENABLE,
        output READY, ERROR, M_OUT, M_OUT_J_ENABLE, M_OUT_K_ENABLE,
        output W_OUT_J_ENABLE, V_OUT_K_ENABLE, E_OUT_K_ENABLE
    );

endinterface

// File: rtl/accelerator_memory_element.sv
// Two-stage fixed-point datapath computing M - M*w*e + w*v for one memory element.
// Stage 1 forms M*w and w*v; stage 2 applies e and the final add/subtract (all arithmetic wraps).
module accelerator_memory_element
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int FRAC_BITS = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] i_m,
    input  logic [DATA_SIZE-1:0] i_w,
    input  logic [DATA_SIZE-1:0] i_e,
    input  logic [DATA_SIZE-1:0] i_v,
    output logic                 o_valid,
    output logic [DATA_SIZE-1:0] o_m
);
    localparam logic [DATA_SIZE-1:0] D_ZERO = DATA_SIZE'(ZERO_DATA);

    // Full-width signed product, arithmetic shift by FRAC_BITS, keep the low DATA_SIZE bits.
    function automatic logic [DATA_SIZE-1:0] fxMul(input logic [DATA_SIZE-1:0] a,
                                                   input logic [DATA_SIZE-1:0] b);
        logic signed [2*DATA_SIZE-1:0] p;
        p = $signed({{DATA_SIZE{a[DATA_SIZE-1]}}, a}) * $signed({{DATA_SIZE{b[DATA_SIZE-1]}}, b});
        return p[FRAC_BITS +: DATA_SIZE];
    endfunction

    logic                 r_s1Valid;
    logic [DATA_SIZE-1:0] r_s1M;
    logic [DATA_SIZE-1:0] r_s1Mw;
    logic [DATA_SIZE-1:0] r_s1E;
    logic [DATA_SIZE-1:0] r_s1Wv;
    logic                 r_s2Valid;
    logic [DATA_SIZE-1:0] r_s2M;
    logic [DATA_SIZE-1:0] w_s2Next;

    assign w_s2Next = r_s1M - fxMul(r_s1Mw, r_s1E) + r_s1Wv;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1Valid <= 1'b0;
            r_s1M     <= D_ZERO;
            r_s1Mw    <= D_ZERO;
            r_s1E     <= D_ZERO;
            r_s1Wv    <= D_ZERO;
            r_s2Valid <= 1'b0;
            r_s2M     <= D_ZERO;
        end else begin
            r_s1Valid <= i_valid;
            r_s1M     <= i_m;
            r_s1Mw    <= fxMul(i_m, i_w);
            r_s1E     <= i_e;
            r_s1Wv    <= fxMul(i_w, i_v);
            r_s2Valid <= r_s1Valid;
            r_s2M     <= r_s1Valid ? w_s2Next : D_ZERO;
        end
    end

    assign o_valid = r_s2Valid;
    assign o_m     = r_s2M;

endmodule

// File: rtl/accelerator_memory_update.sv
// DNC memory update M(t) = M(t-1) - M(t-1)*w*e + w*v, streamed row by row.
// e/v are buffered once per update, w is latched per row, M flows through a 2-cycle element pipeline.
module accelerator_memory_update
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FRAC_BITS    = 16,
    parameter int MAX_W        = 64
) (
    input  logic CLK,
    input  logic RST,
    accelerator_memory_update_if.slave bus
);
    localparam int IDX_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE_CONTROL);
    localparam logic [DATA_SIZE-1:0]    D_ZERO = DATA_SIZE'(ZERO_DATA);

    state_t                  r_state;
    logic [CONTROL_SIZE-1:0] r_n;
    logic [CONTROL_SIZE-1:0] r_w;
    logic [CONTROL_SIZE-1:0] r_j;
    logic [CONTROL_SIZE-1:0] r_k;
    logic                    r_eSeen;
    logic                    r_vSeen;
    logic [DATA_SIZE-1:0]    r_wCur;
    logic [DATA_SIZE-1:0]    r_eBuf [MAX_W];
    logic [DATA_SIZE-1:0]    r_vBuf [MAX_W];
    logic                    r_ready;
    logic                    r_error;
    logic                    r_wReq;
    logic                    r_evReq;
    logic [1:0]              r_firstPipe;
    logic [1:0]              r_lastPipe;

    logic                    w_sizeBad;
    logic                    w_kLast;
    logic                    w_jLast;
    logic                    w_eHave;
    logic                    w_vHave;
    logic                    w_issue;
    logic                    w_outValid;
    logic [IDX_W-1:0]        w_idx;
    logic [DATA_SIZE-1:0]    w_outM;
    logic                    w_unused;

    assign w_sizeBad = (bus.SIZE_N_IN == '0) || (bus.SIZE_W_IN == '0) ||
                       (bus.SIZE_W_IN > DATA_SIZE'(MAX_W));
    assign w_kLast   = (r_k == r_w - C_ONE);
    assign w_jLast   = (r_j == r_n - C_ONE);
    assign w_eHave   = r_eSeen || bus.E_IN_K_ENABLE;
    assign w_vHave   = r_vSeen || bus.V_IN_K_ENABLE;
    assign w_issue   = (r_state == STREAM_M) && bus.M_IN_K_ENABLE;
    assign w_idx     = r_k[IDX_W-1:0];
    assign w_unused  = bus.M_IN_J_ENABLE;

    // Buffers carry no reset: every slot read in STREAM_M was written during this update's LOAD_EV.
    always_ff @(posedge CLK) begin
        if (r_state == LOAD_EV) begin
            if (bus.E_IN_K_ENABLE) r_eBuf[w_idx] <= bus.E_IN;
            if (bus.V_IN_K_ENABLE) r_vBuf[w_idx] <= bus.V_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= STARTER;
            r_n         <= C_ZERO;
            r_w         <= C_ZERO;
            r_j         <= C_ZERO;
            r_k         <= C_ZERO;
            r_eSeen     <= 1'b0;
            r_vSeen     <= 1'b0;
            r_wCur      <= D_ZERO;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
            r_wReq      <= 1'b0;
            r_evReq     <= 1'b0;
            r_firstPipe <= 2'b00;
            r_lastPipe  <= 2'b00;
        end else begin
            r_ready     <= 1'b0;
            r_wReq      <= 1'b0;
            r_evReq     <= 1'b0;
            r_firstPipe <= {r_firstPipe[0], w_issue && (r_k == C_ZERO)};
            r_lastPipe  <= {r_lastPipe[0], w_issue && w_kLast && w_jLast};
            case (r_state)
                STARTER: begin
                    if (bus.START) begin
                        if (w_sizeBad) begin
                            r_error <= 1'b1;
                            r_ready <= 1'b1;
                        end else begin
                            r_error <= 1'b0;
                            r_n     <= CONTROL_SIZE'(bus.SIZE_N_IN);
                            r_w     <= CONTROL_SIZE'(bus.SIZE_W_IN);
                            r_j     <= C_ZERO;
                            r_k     <= C_ZERO;
                            r_eSeen <= 1'b0;
                            r_vSeen <= 1'b0;
                            r_evReq <= 1'b1;
                            r_state <= LOAD_EV;
                        end
                    end
                end
                LOAD_EV: begin
                    // e(k) and v(k) may arrive in either order; advance only once both are held.
                    if (w_eHave && w_vHave) begin
                        r_eSeen <= 1'b0;
                        r_vSeen <= 1'b0;
                        if (w_kLast) begin
                            r_k     <= C_ZERO;
                            r_wReq  <= 1'b1;
                            r_state <= LOAD_W;
                        end else begin
                            r_k     <= r_k + C_ONE;
                            r_evReq <= 1'b1;
                        end
                    end else begin
                        r_eSeen <= w_eHave;
                        r_vSeen <= w_vHave;
                    end
                end
                LOAD_W: begin
                    if (bus.W_IN_J_ENABLE) begin
                        r_wCur  <= bus.W_IN;
                        r_k     <= C_ZERO;
                        r_state <= STREAM_M;
                    end
                end
                STREAM_M: begin
                    if (bus.M_IN_K_ENABLE) begin
                        if (w_kLast) begin
                            r_k <= C_ZERO;
                            if (w_jLast) begin
                                r_state <= ENDER;
                            end else begin
                                r_j     <= r_j + C_ONE;
                                r_wReq  <= 1'b1;
                                r_state <= LOAD_W;
                            end
                        end else begin
                            r_k <= r_k + C_ONE;
                        end
                    end
                end
                ENDER: begin
                    // The tagged last element is on M_OUT now, so READY lands on the following cycle.
                    if (r_lastPipe[1]) begin
                        r_ready <= 1'b1;
                        r_state <= STARTER;
                    end
                end
                default: r_state <= STARTER;
            endcase
        end
    end

    accelerator_memory_element #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_element (
        .CLK     (CLK),
        .RST     (RST),
        .i_valid (w_issue),
        .i_m     (bus.M_IN),
        .i_w     (r_wCur),
        .i_e     (r_eBuf[w_idx]),
        .i_v     (r_vBuf[w_idx]),
        .o_valid (w_outValid),
        .o_m     (w_outM)
    );

    assign bus.READY          = r_ready;
    assign bus.ERROR          = r_error;
    assign bus.M_OUT          = w_outM;
    assign bus.M_OUT_K_ENABLE = w_outValid;
    assign bus.M_OUT_J_ENABLE = w_outValid && r_firstPipe[1];
    assign bus.W_OUT_J_ENABLE = r_wReq;
    assign bus.E_OUT_K_ENABLE = r_evReq;
    assign bus.V_OUT_K_ENABLE = r_evReq;

endmodule

// File: tb/tb_accelerator_memory_update.sv
// Scoreboard bench for accelerator_memory_update: stimulus pushes expected M_OUT words,
// a negedge monitor pops and compares them, including output cycle and row-start strobe.
module tb_accelerator_memory_update;
    localparam logic [63:0] ONE = 64'h10000;

    typedef struct {
        logic [63:0] data;
        logic        jFlag;
        int          cycle;
    } exp_t;

    logic clk;
    logic rst;

    accelerator_memory_update_if #(.DATA_SIZE(64)) bus ();

    accelerator_memory_update #(
        .DATA_SIZE    (64),
        .CONTROL_SIZE (64),
        .FRAC_BITS    (16),
        .MAX_W        (64)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    exp_t        expQ[$];
    int          checkCount = 0;
    int          errorCount = 0;
    int          cycleCount = 0;
    int          readyCount = 0;
    int          outCount   = 0;
    int          jCount     = 0;
    int          reqCount   = 0;
    int          readyBase, outBase, jBase, reqBase;
    int          lastOutCycle = 0;
    int          readyCycle   = 0;
    logic [63:0] eVec [64];
    logic [63:0] vVec [64];
    logic [63:0] wVec [4];
    logic [63:0] mMat [4][64];
    logic [63:0] expMat [4][64];
    int          badN [3] = '{1, 0, 3};
    int          badW [3] = '{65, 2, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference arithmetic (associates M*(w*e); exact for the chosen vectors either way).
    function automatic logic [63:0] fx(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] p;
        p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
        p = p >>> 16;
        return p[63:0];
    endfunction

    function automatic logic [63:0] refElem(input logic [63:0] m, input logic [63:0] w,
                                            input logic [63:0] e, input logic [63:0] v);
        return m - fx(m, fx(w, e)) + fx(w, v);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.M_OUT_K_ENABLE) begin
                outCount++;
                lastOutCycle = cycleCount;
                if (bus.M_OUT_J_ENABLE) jCount++;
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedOut: got M_OUT %h with empty scoreboard", bus.M_OUT);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("mOut", bus.M_OUT, e.data);
                    checkOutput("mOutJ", 64'(bus.M_OUT_J_ENABLE), 64'(e.jFlag));
                    checkOutput("latency", 64'(cycleCount), 64'(e.cycle));
                end
            end
            if (bus.READY) begin
                readyCount++;
                readyCycle = cycleCount;
            end
            if (bus.W_OUT_J_ENABLE || bus.E_OUT_K_ENABLE || bus.V_OUT_K_ENABLE) reqCount++;
        end
    end

    task automatic idleInputs();
        bus.START = 0; bus.SIZE_N_IN = '0; bus.SIZE_W_IN = '0;
        bus.E_IN = '0; bus.E_IN_K_ENABLE = 0; bus.V_IN = '0; bus.V_IN_K_ENABLE = 0;
        bus.W_IN = '0; bus.W_IN_J_ENABLE = 0;
        bus.M_IN = '0; bus.M_IN_J_ENABLE = 0; bus.M_IN_K_ENABLE = 0;
    endtask

    task automatic waitReq(input bit isW, input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = isW ? bus.W_OUT_J_ENABLE : (bus.E_OUT_K_ENABLE && bus.V_OUT_K_ENABLE);
        end
        checkOutput(name, 64'(seen), 64'd1);
    endtask

    // Runs one full update; abortJ >= 0 resets the DUT where row abortJ, k=2 would be driven.
    task automatic applyStimulus(input int n, input int wd, input bit gaps, input int abortJ, input bit restartMid);
        exp_t e;
        readyBase = readyCount; outBase = outCount; jBase = jCount;
        @(posedge clk); #1;
        bus.START = 1; bus.SIZE_N_IN = 64'(n); bus.SIZE_W_IN = 64'(wd);
        @(posedge clk); #1;
        bus.START = 0;
        for (int k = 0; k < wd; k++) begin
            waitReq(1'b0, "evReq");
            @(posedge clk); #1;
            bus.E_IN = eVec[k]; bus.V_IN = vVec[k];
            if (k % 2 == 1) begin
                bus.E_IN_K_ENABLE = 1;
                @(posedge clk); #1;
                bus.E_IN_K_ENABLE = 0; bus.V_IN_K_ENABLE = 1;
            end else begin
                bus.E_IN_K_ENABLE = 1; bus.V_IN_K_ENABLE = 1;
            end
            @(posedge clk); #1;
            bus.E_IN_K_ENABLE = 0; bus.V_IN_K_ENABLE = 0;
        end
        for (int j = 0; j < n; j++) begin
            waitReq(1'b1, "wReq");
            @(posedge clk); #1;
            bus.W_IN = wVec[j]; bus.W_IN_J_ENABLE = 1;
            @(posedge clk); #1;
            bus.W_IN_J_ENABLE = 0;
            for (int k = 0; k < wd; k++) begin
                if (j == abortJ && k == 2) begin
                    checkOutput("pendingAtAbort", 64'(expQ.size()), 64'd2);
                    rst = 1;
                    #1;
                    checkOutput("abortStrobes", {57'd0, bus.READY, bus.ERROR, bus.M_OUT_K_ENABLE,
                        bus.M_OUT_J_ENABLE, bus.W_OUT_J_ENABLE, bus.E_OUT_K_ENABLE, bus.V_OUT_K_ENABLE}, 64'd0);
                    checkOutput("abortMOut", bus.M_OUT, 64'd0);
                    expQ.delete();
                    idleInputs();
                    @(posedge clk); #1;
                    rst = 0;
                    return;
                end
                bus.M_IN = mMat[j][k]; bus.M_IN_K_ENABLE = 1; bus.M_IN_J_ENABLE = (k == 0);
                if (restartMid && j == 1 && k == 1) begin
                    bus.START = 1; bus.SIZE_N_IN = 64'd1; bus.SIZE_W_IN = 64'd1;
                end
                e.data = expMat[j][k]; e.jFlag = (k == 0); e.cycle = cycleCount + 2;
                expQ.push_back(e);
                @(posedge clk); #1;
                bus.M_IN_K_ENABLE = 0; bus.M_IN_J_ENABLE = 0; bus.START = 0;
                if (gaps) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic waitDone(input int expOuts, input int expJ);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (readyCount > readyBase);
        end
        checkOutput("readyTimeout", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("readyCount", 64'(readyCount - readyBase), 64'd1);
        checkOutput("readyAfterLast", 64'(readyCycle), 64'(lastOutCycle + 1));
        checkOutput("outCount", 64'(outCount - outBase), 64'(expOuts));
        checkOutput("jCount", 64'(jCount - jBase), 64'(expJ));
        checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 0;
        idleInputs();
        #2 rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetStrobes", {57'd0, bus.READY, bus.ERROR, bus.M_OUT_K_ENABLE, bus.M_OUT_J_ENABLE,
            bus.W_OUT_J_ENABLE, bus.E_OUT_K_ENABLE, bus.V_OUT_K_ENABLE}, 64'd0);
        checkOutput("resetMOut", bus.M_OUT, 64'd0);
        @(posedge clk); #1;
        rst = 0;

        $display("[TB] N=2 W=2 erase/write rows");
        eVec[0] = ONE; eVec[1] = ONE; vVec[0] = 64'h8000; vVec[1] = 64'h8000;
        wVec[0] = ONE; wVec[1] = 64'h0;
        for (int k = 0; k < 2; k++) begin
            mMat[0][k] = 64'h30000; mMat[1][k] = 64'h30000;
            expMat[0][k] = 64'h8000; expMat[1][k] = 64'h30000;
        end
        applyStimulus(2, 2, 1'b0, -1, 1'b0);
        waitDone(4, 2);

        $display("[TB] N=1 W=1 latency");
        eVec[0] = 64'h0; vVec[0] = ONE; wVec[0] = 64'h8000;
        mMat[0][0] = 64'h20000; expMat[0][0] = 64'h28000;
        applyStimulus(1, 1, 1'b1, -1, 1'b0);
        waitDone(1, 1);

        $display("[TB] illegal sizes");
        for (int i = 0; i < 3; i++) begin
            reqBase = reqCount;
            @(posedge clk); #1;
            bus.START = 1; bus.SIZE_N_IN = 64'(badN[i]); bus.SIZE_W_IN = 64'(badW[i]);
            @(posedge clk); #1;
            bus.START = 0;
            @(negedge clk);
            checkOutput("errReady", 64'(bus.READY), 64'd1);
            checkOutput("errFlag", 64'(bus.ERROR), 64'd1);
            @(negedge clk);
            checkOutput("errReadyPulse", 64'(bus.READY), 64'd0);
            checkOutput("errSticky", 64'(bus.ERROR), 64'd1);
            repeat (3) @(negedge clk);
            checkOutput("errNoReq", 64'(reqCount - reqBase), 64'd0);
        end

        $display("[TB] N=3 W=4 back-to-back with ignored mid-stream START");
        eVec[0] = ONE; eVec[1] = 64'h8000; eVec[2] = 64'h0; eVec[3] = 64'h4000;
        vVec[0] = ONE; vVec[1] = 64'h20000; vVec[2] = 64'hFFFF_FFFF_FFFF_0000; vVec[3] = 64'h8000;
        wVec[0] = 64'h8000; wVec[1] = ONE; wVec[2] = 64'h20000;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 4; k++) begin
                mMat[j][k] = 64'(longint'(j * 65536 - k * 32768 + 16384));
                expMat[j][k] = refElem(mMat[j][k], wVec[j], eVec[k], vVec[k]);
            end
        applyStimulus(3, 4, 1'b0, -1, 1'b1);
        waitDone(12, 3);
        checkOutput("errorCleared", 64'(bus.ERROR), 64'd0);

        $display("[TB] reset at j=1 k=2, then rerun");
        applyStimulus(3, 4, 1'b0, 1, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("noReadyAfterAbort", 64'(readyCount - readyBase), 64'd0);
        checkOutput("outsBeforeAbort", 64'(outCount - outBase), 64'd4);
        applyStimulus(3, 4, 1'b0, -1, 1'b0);
        waitDone(12, 3);

        $display("[TB] N=1 W=MAX_W with gaps");
        wVec[0] = ONE;
        for (int k = 0; k < 64; k++) begin
            eVec[k] = (k % 2 == 0) ? ONE : 64'h0;
            vVec[k] = 64'(k) << 12;
            mMat[0][k] = 64'(k) * 64'h1000;
            expMat[0][k] = refElem(mMat[0][k], wVec[0], eVec[k], vVec[k]);
        end
        applyStimulus(1, 64, 1'b1, -1, 1'b0);
        waitDone(64, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
